inst_fetch: RTL and testbench

Instruction-fetch stage of the LEGv8 pipeline and the direct upstream producer of the 32-bit instruction word consumed by decode and sign_extend. It owns the PC and issues in-order requests to a synchronous instruction memory with a fixed 1-cycle read latency. A 2-entry output buffer absorbs the in-flight response while decode stalls. Branch redirects from downstream flush all in-flight and buffered instructions.

---
 rtl/inst_fetch.sv | 123 ++++++++++++
 tb/tb_inst_fetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Brief    : LEGv8 fetch stage. Owns the PC, issues in-order reads to a
//            1-cycle synchronous instruction memory and holds up to two
//            fetched words in a small output FIFO while decode stalls.
// Revision : 1.0  initial release
// ============================================================================
module inst_fetch #(
    parameter int              WORD      = 64,
    parameter int              INST_SIZE = 32,
    parameter logic [WORD-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_en,
    output logic [WORD-1:0]      imem_addr,
    input  logic [INST_SIZE-1:0] imem_rdata,
    input  logic                 br_taken,
    input  logic [WORD-1:0]      br_target,
    input  logic                 id_ready,
    output logic                 if_valid,
    output logic [WORD-1:0]      if_pc,
    output logic [INST_SIZE-1:0] if_inst
);

    localparam logic [WORD-1:0] c_PC_STEP    = WORD'(4);
    localparam logic [WORD-1:0] c_ALIGN_MASK = ~WORD'(3);

    // Fetch state
    logic [WORD-1:0]      r_pc;
    logic                 r_inflight;
    logic [WORD-1:0]      r_inflight_pc;

    // Output FIFO, entry 0 is always the head
    logic [1:0]           r_count;
    logic [WORD-1:0]      r_e0_pc;
    logic [INST_SIZE-1:0] r_e0_inst;
    logic [WORD-1:0]      r_e1_pc;
    logic [INST_SIZE-1:0] r_e1_inst;

    logic                 w_pop;
    logic                 w_push;
    logic [1:0]           w_occ_after_pop;
    logic [WORD-1:0]      w_target;

    assign w_pop    = (r_count != 2'd0) & id_ready;
    assign w_push   = r_inflight & ~br_taken;
    assign w_target = br_target & c_ALIGN_MASK;

    // Slots already committed (buffered + in flight) once this cycle's pop retires
    assign w_occ_after_pop = r_count + {1'b0, r_inflight} - {1'b0, w_pop};

    assign imem_en   = rst_n & ~br_taken & (w_occ_after_pop < 2'd2);
    assign imem_addr = r_pc;

    assign if_valid = (r_count != 2'd0);
    assign if_pc    = r_e0_pc;
    assign if_inst  = r_e0_inst;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (br_taken) begin
            r_pc       <= w_target;
            r_inflight <= 1'b0;
        end else if (imem_en) begin
            r_pc          <= r_pc + c_PC_STEP;
            r_inflight_pc <= r_pc;
            r_inflight    <= 1'b1;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= 2'd0;
            r_e0_pc   <= '0;
            r_e0_inst <= '0;
            r_e1_pc   <= '0;
            r_e1_inst <= '0;
        end else if (br_taken) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b01: begin
                    r_e0_pc   <= r_e1_pc;
                    r_e0_inst <= r_e1_inst;
                    r_count   <= r_count - 2'd1;
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_e0_pc   <= r_inflight_pc;
                        r_e0_inst <= imem_rdata;
                    end else begin
                        r_e1_pc   <= r_inflight_pc;
                        r_e1_inst <= imem_rdata;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: the new word lands behind whatever remains
                    if (r_count == 2'd1) begin
                        r_e0_pc   <= r_inflight_pc;
                        r_e0_inst <= imem_rdata;
                    end else begin
                        r_e0_pc   <= r_e1_pc;
                        r_e0_inst <= r_e1_inst;
                        r_e1_pc   <= r_inflight_pc;
                        r_e1_inst <= imem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Brief    : Self-checking bench for inst_fetch against an in-order stream model.
// Revision : 1.0  initial release
// ============================================================================
module tb_inst_fetch;

    localparam logic [63:0] c_RESET_PC = 64'h0;

    logic        clk;
    logic        rst_n;
    logic        imem_en;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        br_taken;
    logic [63:0] br_target;
    logic        id_ready;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_inst;

    int n_checks = 0;
    int n_pass   = 0;

    // Stream model: addresses are fetched and delivered strictly in sequence
    logic [63:0] m_fetch;
    logic [63:0] m_deliver;
    int          m_outst;
    int          m_inflight;
    int          m_obs_occ;
    bit          m_known;
    bit          m_after_rst;

    inst_fetch #(
        .WORD      (64),
        .INST_SIZE (32),
        .RESET_PC  (c_RESET_PC)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .id_ready   (id_ready),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_inst    (if_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [63:0] a);
        case (a)
            64'd0:   return 32'hF84402C9;
            64'd4:   return 32'h8B09026A;
            64'd8:   return 32'hCB0A028B;
            64'd12:  return 32'hF80602CB;
            64'd16:  return 32'hB4FFFF6B;
            default: return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= memf(imem_addr);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc(input logic rst_v, input logic br_v, input logic rdy_v, input logic [63:0] tgt);
        bit exp_valid;
        bit exp_pop;
        bit exp_en;
        @(negedge clk);
        rst_n     = rst_v;
        br_taken  = br_v;
        br_target = tgt;
        id_ready  = rdy_v;
        #1;
        exp_valid = (m_outst - m_inflight) > 0;
        exp_pop   = exp_valid && rdy_v;
        exp_en    = rst_v && !br_v && ((m_outst - int'(exp_pop)) < 2);
        if (m_known) begin
            check_eq("imem_en", 64'(imem_en), 64'(exp_en));
            check_eq("if_valid", 64'(if_valid), 64'(exp_valid));
            if (exp_valid) begin
                check_eq("if_pc", if_pc, m_deliver);
                check_eq("if_inst", 64'(if_inst), 64'(memf(m_deliver)));
            end
            if (exp_en) check_eq("imem_addr", imem_addr, m_fetch);
            if (m_after_rst) begin
                check_eq("rst_if_pc", if_pc, 64'h0);
                check_eq("rst_if_inst", 64'(if_inst), 64'h0);
            end
        end
        if (!rst_v) begin
            m_fetch     = c_RESET_PC;
            m_deliver   = c_RESET_PC;
            m_outst     = 0;
            m_inflight  = 0;
            m_obs_occ   = 0;
            m_known     = 1'b1;
            m_after_rst = 1'b1;
        end else if (br_v) begin
            m_fetch     = tgt & ~64'd3;
            m_deliver   = tgt & ~64'd3;
            m_outst     = 0;
            m_inflight  = 0;
            m_obs_occ   = 0;
            m_after_rst = 1'b0;
        end else if (m_known) begin
            m_after_rst = 1'b0;
            if (exp_pop) m_deliver = m_deliver + 64'd4;
            if (exp_en)  m_fetch   = m_fetch + 64'd4;
            m_outst    = m_outst + int'(exp_en) - int'(exp_pop);
            m_inflight = int'(exp_en);
            // Occupancy seen purely from the DUT's own handshakes must never exceed the buffer
            m_obs_occ  = m_obs_occ + int'(imem_en) - int'(if_valid && rdy_v);
            check_eq("occupancy_le_2", 64'(m_obs_occ <= 2), 64'd1);
        end
    endtask

    task automatic run(input int n, input logic rdy_v);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, rdy_v, 64'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        br_taken   = 1'b0;
        br_target  = '0;
        id_ready   = 1'b0;
        m_fetch    = '0;
        m_deliver  = '0;
        m_outst    = 0;
        m_inflight = 0;
        m_obs_occ  = 0;
        m_known    = 1'b0;
        m_after_rst = 1'b0;

        cyc(1'b0, 1'b0, 1'b1, 64'h0);
        cyc(1'b0, 1'b0, 1'b1, 64'h0);

        // Streaming start, then a 5-cycle stall after the first delivery
        run(3, 1'b1);
        run(5, 1'b0);
        run(6, 1'b1);

        // Redirect to -4: exercises wrap of the fetch PC back to zero
        cyc(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        run(6, 1'b1);

        // Redirect while the buffer is full and decode is stalled
        run(5, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 64'h100);
        run(6, 1'b1);

        // Misaligned target
        cyc(1'b1, 1'b1, 1'b1, 64'h103);
        run(5, 1'b1);

        // Back-to-back redirects: the last one wins
        cyc(1'b1, 1'b1, 1'b1, 64'h200);
        cyc(1'b1, 1'b1, 1'b1, 64'h300);
        run(5, 1'b1);

        // Reset in the middle of a stalled stream
        run(4, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 64'h0);
        run(6, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            logic        r;
            logic        b;
            logic        y;
            logic [63:0] t;
            r = ($urandom_range(0, 199) != 0);
            b = ($urandom_range(0, 19) == 0);
            y = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 2))
                0:       t = 64'($urandom_range(0, 255));
                1:       t = {$urandom, $urandom};
                default: t = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
            endcase
            cyc(r, b, y, t);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
